// File: rtl/minisys_cp0_pkg.sv
// Shared CP0 definitions for the Minisys-1A write-back exception unit:
// register indices, exception codes, field positions and the FSM states.
package minisys_cp0_pkg;

   // CP0 register indices as seen by MFC0/MTC0
   localparam logic [4:0] IDX_STATUS = 5'd12;
   localparam logic [4:0] IDX_CAUSE  = 5'd13;
   localparam logic [4:0] IDX_EPC    = 5'd14;

   // Cause.ExcCode values
   localparam logic [4:0] EXC_INT     = 5'd0;
   localparam logic [4:0] EXC_DIVZERO = 5'd7;
   localparam logic [4:0] EXC_SYS     = 5'd8;
   localparam logic [4:0] EXC_BP      = 5'd9;
   localparam logic [4:0] EXC_RI      = 5'd10;
   localparam logic [4:0] EXC_OV      = 5'd12;

   // Status / Cause field positions
   localparam int STATUS_IE   = 0;
   localparam int STATUS_EXL  = 1;
   localparam int STATUS_IM_LO = 10;
   localparam int STATUS_IM_HI = 15;

   // Only IM, EXL and IE exist in Status; everything else reads 0
   localparam logic [31:0] STATUS_WMASK = 32'h0000_FC03;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

endpackage

// File: rtl/wb_cp0_exception_unit_if.sv
// WB-stage instruction bus into the exception unit and the redirect/flush
// response back to the pipeline front end.
interface wb_cp0_exception_unit_if;
   logic        WB_Valid;
   logic        WB_Overflow;
   logic        WB_Divide_zero;
   logic        WB_Syscall;
   logic        WB_Break;
   logic        WB_Eret;
   logic        WB_Reserved_instruction;
   logic        WB_Mfc0;
   logic        WB_Mtc0;
   logic [31:0] WB_PC;
   logic [31:0] WB_opcplus4;
   logic [4:0]  WB_rd;
   logic [31:0] WB_rt_value;
   logic [31:0] cp0_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush;

   // Pipeline side: drives the WB instruction, receives the response
   modport master (
      output WB_Valid, WB_Overflow, WB_Divide_zero, WB_Syscall, WB_Break,
             WB_Eret, WB_Reserved_instruction, WB_Mfc0, WB_Mtc0,
             WB_PC, WB_opcplus4, WB_rd, WB_rt_value,
      input  cp0_rdata, redirect_valid, redirect_pc, flush
   );

   // Exception unit side
   modport slave (
      input  WB_Valid, WB_Overflow, WB_Divide_zero, WB_Syscall, WB_Break,
             WB_Eret, WB_Reserved_instruction, WB_Mfc0, WB_Mtc0,
             WB_PC, WB_opcplus4, WB_rd, WB_rt_value,
      output cp0_rdata, redirect_valid, redirect_pc, flush
   );
endinterface

// File: rtl/cp0_regs.sv
// CP0 Status/Cause/EPC storage with an MTC0 write port, an exception/ERET
// update port and a zero-latency read mux.
module cp0_regs
   import minisys_cp0_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [5:0]  ip,
   input  logic        exc_take,
   input  logic [4:0]  exc_code,
   input  logic [31:0] exc_epc,
   input  logic        eret_take,
   input  logic        mtc0_we,
   input  logic [4:0]  mtc0_idx,
   input  logic [31:0] mtc0_data,
   input  logic [4:0]  rd_idx,
   output logic [31:0] rdata,
   output logic [31:0] status,
   output logic [31:0] cause,
   output logic [31:0] epc,
   output logic        int_pending
);

   logic [31:0] status_reg;
   logic [4:0]  exc_code_reg;
   logic [31:0] epc_reg;

   // MTC0 writes land first; an exception/ERET in the same cycle then
   // overrides EXL (and EPC) so the event always wins on shared fields.
   always_ff @(posedge clock) begin
      if (!reset) begin
         status_reg   <= '0;
         exc_code_reg <= '0;
         epc_reg      <= '0;
      end else begin
         if (mtc0_we && mtc0_idx == IDX_STATUS)
            status_reg <= mtc0_data & STATUS_WMASK;
         if (mtc0_we && mtc0_idx == IDX_EPC)
            epc_reg <= mtc0_data;
         if (exc_take) begin
            exc_code_reg           <= exc_code;
            status_reg[STATUS_EXL] <= 1'b1;
            // A nested exception keeps the original return address
            if (!status_reg[STATUS_EXL])
               epc_reg <= exc_epc;
         end else if (eret_take) begin
            status_reg[STATUS_EXL] <= 1'b0;
         end
      end
   end

   // Cause.IP mirrors the synchroniser output directly
   assign status = status_reg;
   assign cause  = {16'b0, ip, 3'b0, exc_code_reg, 2'b0};
   assign epc    = epc_reg;

   assign int_pending = status_reg[STATUS_IE] & ~status_reg[STATUS_EXL] &
                        (|(ip & status_reg[STATUS_IM_HI:STATUS_IM_LO]));

   // MFC0 read mux; unimplemented indices read as zero
   always_comb begin
      rdata = '0;
      case (rd_idx)
         IDX_STATUS: rdata = status_reg;
         IDX_CAUSE:  rdata = cause;
         IDX_EPC:    rdata = epc_reg;
         default:    rdata = '0;
      endcase
   end

endmodule

// File: rtl/wb_cp0_exception_unit.sv
// Write-back exception unit: prioritises WB-stage exceptions, ERET and
// external interrupts, and turns the winner into a one-cycle redirect plus
// a FLUSH_CYCLES-long pipeline flush.
module wb_cp0_exception_unit
   import minisys_cp0_pkg::*;
#(
   parameter logic [31:0] HANDLER_ADDR = 32'h0000_F000,
   parameter int          FLUSH_CYCLES = 3
)(
   input  logic                    clock,
   input  logic                    reset,
   wb_cp0_exception_unit_if.slave  bus,
   input  logic [5:0]              ext_int,
   output logic [31:0]             status,
   output logic [31:0]             cause,
   output logic [31:0]             epc
);

   localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

   state_t      state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic        flush_reg;
   logic        redirect_valid_reg;
   logic [31:0] redirect_pc_reg;
   logic [5:0]  sync1_reg;
   logic [5:0]  sync2_reg;

   logic        accept;
   logic        any_sync;
   logic        epc_from_pc;
   logic [4:0]  sync_code;
   logic        sync_take;
   logic        eret_take;
   logic        int_take;
   logic        int_pending;
   logic        exc_take;
   logic [4:0]  exc_code;
   logic [31:0] exc_epc;
   logic        mtc0_we;
   logic        event_take;

   // Two-flop synchroniser for the asynchronous interrupt lines
   always_ff @(posedge clock) begin
      if (!reset) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
      end else begin
         sync1_reg <= ext_int;
         sync2_reg <= sync1_reg;
      end
   end

   // Fixed-priority encoder: RI > Ov > DivZero > Sys > Bp
   always_comb begin
      any_sync    = 1'b1;
      epc_from_pc = 1'b0;
      sync_code   = EXC_INT;
      if (bus.WB_Reserved_instruction) begin
         sync_code = EXC_RI;      epc_from_pc = 1'b1;
      end else if (bus.WB_Overflow) begin
         sync_code = EXC_OV;      epc_from_pc = 1'b1;
      end else if (bus.WB_Divide_zero) begin
         sync_code = EXC_DIVZERO; epc_from_pc = 1'b1;
      end else if (bus.WB_Syscall) begin
         sync_code = EXC_SYS;
      end else if (bus.WB_Break) begin
         sync_code = EXC_BP;
      end else begin
         any_sync = 1'b0;
      end
   end

   // Nothing is acted on for bubbles or while the pipeline is being flushed
   assign accept     = bus.WB_Valid && (state_reg == RUN);
   assign sync_take  = accept && any_sync;
   assign eret_take  = accept && !any_sync && bus.WB_Eret;
   assign int_take   = accept && !any_sync && !bus.WB_Eret && int_pending;
   assign exc_take   = sync_take || int_take;
   assign exc_code   = int_take ? EXC_INT : sync_code;
   assign exc_epc    = (sync_take && epc_from_pc) ? bus.WB_PC : bus.WB_opcplus4;
   assign mtc0_we    = accept && bus.WB_Mtc0 && !any_sync;
   assign event_take = exc_take || eret_take;

   cp0_regs u_regs (
      .clock       (clock),
      .reset       (reset),
      .ip          (sync2_reg),
      .exc_take    (exc_take),
      .exc_code    (exc_code),
      .exc_epc     (exc_epc),
      .eret_take   (eret_take),
      .mtc0_we     (mtc0_we),
      .mtc0_idx    (bus.WB_rd),
      .mtc0_data   (bus.WB_rt_value),
      .rd_idx      (bus.WB_rd),
      .rdata       (bus.cp0_rdata),
      .status      (status),
      .cause       (cause),
      .epc         (epc),
      .int_pending (int_pending)
   );

   // RUN/FLUSH sequencer with registered redirect and flush outputs
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_reg          <= RUN;
         cnt_reg            <= '0;
         flush_reg          <= 1'b0;
         redirect_valid_reg <= 1'b0;
         redirect_pc_reg    <= '0;
      end else begin
         redirect_valid_reg <= 1'b0;
         case (state_reg)
            RUN: begin
               if (event_take) begin
                  state_reg          <= FLUSH;
                  cnt_reg            <= CNT_LOAD;
                  flush_reg          <= 1'b1;
                  redirect_valid_reg <= 1'b1;
                  // ERET returns to the EPC held before this cycle's update
                  redirect_pc_reg    <= eret_take ? epc : HANDLER_ADDR;
               end
            end
            FLUSH: begin
               if (cnt_reg == '0) begin
                  state_reg <= RUN;
                  flush_reg <= 1'b0;
               end else begin
                  cnt_reg <= cnt_reg - CNT_W'(1);
               end
            end
            default: state_reg <= RUN;
         endcase
      end
   end

   assign bus.redirect_valid = redirect_valid_reg;
   assign bus.redirect_pc    = redirect_pc_reg;
   assign bus.flush          = flush_reg;

endmodule
